// File: rtl/leading_zero_skip_divider.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : leading_zero_skip_divider
//  Purpose  : Sequential 32-bit restoring divider for RISC-V DIV/DIVU/REM/REMU.
//             Iteration starts at the most-significant set bit of the dividend
//             magnitude, so leading zero bits cost no cycles. Uses the same
//             start/busy/done/result/rd-index handshake as the column-bypass
//             multiplier.
//  Ports    : clk_i, rst_i (async, active-high)
//             start_i, op_a_i (dividend), op_b_i (divisor), rem_i, signed_i,
//             rd_idx_i                        -- request, sampled on accept
//             busy_o, done_o (1-cycle pulse), result_o, result_rd_idx_o
//  Options  : LZS_DIVIDER_SIGNED_EN -- when defined, signed_i selects signed
//             division; otherwise signed_i is ignored and all ops are unsigned.
//  Revision : 1.0 - initial release
// ============================================================================
module leading_zero_skip_divider (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [31:0] op_a_i,
    input  logic [31:0] op_b_i,
    input  logic        rem_i,
    input  logic        signed_i,
    input  logic [4:0]  rd_idx_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [31:0] result_o,
    output logic [4:0]  result_rd_idx_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_next;

    logic [31:0] r_n;       // dividend magnitude
    logic [31:0] r_d;       // divisor magnitude
    logic [31:0] r_q;       // quotient
    logic [31:0] r_r;       // partial remainder (always < D, so 32 bits hold it)
    logic [4:0]  r_idx;     // dividend bit being consumed
    logic [4:0]  r_rd;
    logic        r_rem;
    logic        r_done;
    logic [31:0] r_result;
    logic [4:0]  r_result_rd;

    logic [31:0] w_n_mag;
    logic [31:0] w_d_mag;
    logic [4:0]  w_msb;
    logic [32:0] w_t;
    logic [32:0] w_diff;
    logic        w_ge;
    logic [31:0] w_q_fix;
    logic [31:0] w_r_fix;

`ifdef LZS_DIVIDER_SIGNED_EN
    logic        w_sa;
    logic        w_sb;
    logic        r_neg_q;
    logic        r_neg_r;

    assign w_sa    = signed_i & op_a_i[31];
    assign w_sb    = signed_i & op_b_i[31];
    assign w_n_mag = w_sa ? (~op_a_i + 32'd1) : op_a_i;
    assign w_d_mag = w_sb ? (~op_b_i + 32'd1) : op_b_i;
    assign w_q_fix = r_neg_q ? (~r_q + 32'd1) : r_q;
    assign w_r_fix = r_neg_r ? (~r_r + 32'd1) : r_r;
`else
    logic        w_unused_signed;

    // signed_i stays on the port list so both builds share one pinout
    assign w_unused_signed = signed_i;
    assign w_n_mag = op_a_i;
    assign w_d_mag = op_b_i;
    assign w_q_fix = r_q;
    assign w_r_fix = r_r;
`endif

    // Index of the highest set bit of the dividend magnitude (0 when N == 0)
    always_comb begin
        w_msb = 5'd0;
        for (int i = 0; i < 32; i++) begin
            if (w_n_mag[i]) begin
                w_msb = 5'(i);
            end
        end
    end

    // Since R < D before each shift, T < 2D and T - D < 2^32 whenever T >= D.
    // The borrow bit of the 33-bit difference is therefore the compare result.
    assign w_t    = {r_r, r_n[r_idx]};
    assign w_diff = w_t - {1'b0, r_d};
    assign w_ge   = ~w_diff[32];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start_i) begin
                    w_state_next = ((w_d_mag == 32'd0) || (w_n_mag == 32'd0)) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (r_idx == 5'd0) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_n         <= 32'd0;
            r_d         <= 32'd0;
            r_q         <= 32'd0;
            r_r         <= 32'd0;
            r_idx       <= 5'd0;
            r_rd        <= 5'd0;
            r_rem       <= 1'b0;
            r_done      <= 1'b0;
            r_result    <= 32'd0;
            r_result_rd <= 5'd0;
`ifdef LZS_DIVIDER_SIGNED_EN
            r_neg_q     <= 1'b0;
            r_neg_r     <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start_i) begin
                        r_n   <= w_n_mag;
                        r_d   <= w_d_mag;
                        r_rem <= rem_i;
                        r_rd  <= rd_idx_i;
                        r_idx <= w_msb;
                        r_q   <= 32'd0;
                        r_r   <= 32'd0;
`ifdef LZS_DIVIDER_SIGNED_EN
                        r_neg_q <= w_sa ^ w_sb;
                        r_neg_r <= w_sa;
`endif
                        // Divide-by-zero: final values preloaded, remainder is
                        // the raw dividend, and no sign fixup may touch them.
                        if (w_d_mag == 32'd0) begin
                            r_q <= 32'hFFFF_FFFF;
                            r_r <= op_a_i;
`ifdef LZS_DIVIDER_SIGNED_EN
                            r_neg_q <= 1'b0;
                            r_neg_r <= 1'b0;
`endif
                        end
                    end
                end
                S_RUN: begin
                    r_r <= w_ge ? w_diff[31:0] : w_t[31:0];
                    if (w_ge) begin
                        r_q[r_idx] <= 1'b1;
                    end
                    r_idx <= r_idx - 5'd1;
                end
                S_DONE: begin
                    r_result    <= r_rem ? w_r_fix : w_q_fix;
                    r_result_rd <= r_rd;
                    r_done      <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign busy_o          = (r_state == S_RUN) || (r_state == S_DONE);
    assign done_o          = r_done;
    assign result_o        = r_result;
    assign result_rd_idx_o = r_result_rd;

endmodule
`default_nettype wire
